hw_mutex_arbiter: RTL and testbench

Arbitrated hardware mutex for the cluster event unit. It collects lock requests from up to NB_CORES per-core event-unit slices and grants ownership to exactly one core at a time. Lock transfers directly from the releasing owner to the next waiter, and a message word written at unlock is passed to the next owner. It sits between the per-core lock/unlock request lines and the per-core mutex event lines of the cluster event map, one instance per hardware mutex.

---
 rtl/hw_mutex_arbiter.sv | 128 ++++++++++++
 tb/tb_hw_mutex_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hw_mutex_arbiter.sv
// Arbitrated hardware mutex: grants one owner at a time, hands the lock directly to the next
// waiter and passes a message word between owners. HW_MUTEX_RR_EN selects round-robin arbitration.
module hw_mutex_arbiter #(
    parameter int unsigned  NB_CORES    = 8,
    parameter int unsigned  MUTEX_MSG_W = 32,
    localparam int unsigned ID_W        = $clog2(NB_CORES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NB_CORES-1:0]    lock_req_i,
    input  logic [NB_CORES-1:0]    unlock_req_i,
    input  logic [MUTEX_MSG_W-1:0] msg_wdata_i,
    output logic [MUTEX_MSG_W-1:0] msg_rdata_o,
    output logic [NB_CORES-1:0]    grant_event_o,
    output logic                   owner_valid_o,
    output logic [ID_W-1:0]        owner_id_o,
    output logic [NB_CORES-1:0]    pending_o,
    output logic                   error_o
);

    typedef enum logic [0:0] {StFree, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [NB_CORES-1:0]    pending_q, pending_d;
    logic [NB_CORES-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [MUTEX_MSG_W-1:0] msg_q, msg_d;
    logic                   error_q, error_d;

    logic [NB_CORES-1:0]    req_vec;
    logic [NB_CORES-1:0]    owner_oh;
    logic [ID_W-1:0]        winner;
    logic                   unlock_ok;

    // Same-cycle requests take part in arbitration alongside latched waiters.
    assign req_vec = pending_q | lock_req_i;

`ifdef HW_MUTEX_RR_EN
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] idx;

    // Scan from farthest to nearest offset so the first set bit after rr_ptr wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NB_CORES; i >= 1; i--) begin
            idx = ID_W'((32'(rr_ptr_q) + 32'(i)) % 32'(NB_CORES));
            if (req_vec[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= ID_W'(NB_CORES - 1);
        end else if (|grant_d) begin
            rr_ptr_q <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        owner_d   = owner_q;
        msg_d     = msg_q;
        grant_d   = '0;
        owner_oh  = '0;
        owner_oh[owner_q] = 1'b1;

        unlock_ok = (state_q == StLocked) && unlock_req_i[owner_q];
        // Any unlock bit not belonging to the current owner is illegal.
        error_d   = (state_q == StLocked) ? |(unlock_req_i & ~owner_oh) : |unlock_req_i;

        if (state_q == StFree || unlock_ok) begin
            if (unlock_ok) begin
                msg_d = msg_wdata_i;
            end
            if (|req_vec) begin
                state_d          = StLocked;
                owner_d          = winner;
                grant_d[winner]  = 1'b1;
                pending_d        = req_vec & ~grant_d;
            end else begin
                state_d   = StFree;
                pending_d = '0;
            end
        end else begin
            pending_d = pending_q | lock_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StFree;
            pending_q <= '0;
            owner_q   <= '0;
            msg_q     <= '0;
            grant_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            owner_q   <= owner_d;
            msg_q     <= msg_d;
            grant_q   <= grant_d;
            error_q   <= error_d;
        end
    end

    assign msg_rdata_o   = msg_q;
    assign grant_event_o = grant_q;
    assign owner_valid_o = (state_q == StLocked);
    assign owner_id_o    = owner_q;
    assign pending_o     = pending_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_hw_mutex_arbiter.sv
// Scoreboard bench for hw_mutex_arbiter: a queue-and-integer reference model predicts every
// cycle's outputs; a separate monitor pops and compares them one cycle after each stimulus.
module tb_hw_mutex_arbiter;
    localparam int N  = 8;
    localparam int MW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  lock_req, unlock_req, grant_event, pending;
    logic [MW-1:0] msg_wdata, msg_rdata;
    logic          owner_valid, error;
    logic [2:0]    owner_id;

    always #5 clk = ~clk;

    hw_mutex_arbiter #(.NB_CORES(N), .MUTEX_MSG_W(MW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lock_req_i   (lock_req),
        .unlock_req_i (unlock_req),
        .msg_wdata_i  (msg_wdata),
        .msg_rdata_o  (msg_rdata),
        .grant_event_o(grant_event),
        .owner_valid_o(owner_valid),
        .owner_id_o   (owner_id),
        .pending_o    (pending),
        .error_o      (error)
    );

    typedef struct {
        logic [N-1:0]  grant;
        logic          valid;
        logic          chk_id;
        logic [2:0]    id;
        logic [N-1:0]  pend;
        logic          err;
        logic [MW-1:0] msg;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: owner index or -1 when free.
    int            m_owner = -1;
    logic [N-1:0]  m_pend  = '0;
    int            m_rr    = N - 1;
    logic [MW-1:0] m_msg   = '0;

    function automatic int pick(input logic [N-1:0] req);
`ifdef HW_MUTEX_RR_EN
        for (int off = 1; off <= N; off++) begin
            if (req[(m_rr + off) % N]) return (m_rr + off) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (req[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic step(input logic r, input logic [N-1:0] lk, input logic [N-1:0] ul,
                        input logic [MW-1:0] wd);
        exp_t         e;
        logic [N-1:0] req;
        bit           ok;
        int           w;
        @(negedge clk);
        rst        = r;
        lock_req   = lk;
        unlock_req = ul;
        msg_wdata  = wd;
        e.grant  = '0;
        e.err    = 1'b0;
        e.chk_id = 1'b0;
        e.id     = '0;
        if (r) begin
            m_owner  = -1;
            m_pend   = '0;
            m_rr     = N - 1;
            m_msg    = '0;
            e.chk_id = 1'b1;
        end else begin
            req = m_pend | lk;
            ok  = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (ul[k]) begin
                    if (m_owner == k) ok = 1'b1;
                    else e.err = 1'b1;
                end
            end
            if (m_owner < 0 || ok) begin
                if (ok) m_msg = wd;
                w = pick(req);
                if (w >= 0) begin
                    m_owner    = w;
                    m_rr       = w;
                    req[w]     = 1'b0;
                    e.grant[w] = 1'b1;
                end else begin
                    m_owner = -1;
                end
                m_pend = req;
            end else begin
                m_pend = m_pend | lk;
            end
        end
        e.valid = (m_owner >= 0);
        if (m_owner >= 0) begin
            e.chk_id = 1'b1;
            e.id     = 3'(m_owner);
        end
        e.pend = m_pend;
        e.msg  = m_msg;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grant_event", 64'(grant_event), 64'(e.grant));
                chk("owner_valid", 64'(owner_valid), 64'(e.valid));
                if (e.chk_id) chk("owner_id", 64'(owner_id), 64'(e.id));
                chk("pending", 64'(pending), 64'(e.pend));
                chk("error", 64'(error), 64'(e.err));
                chk("msg_rdata", 64'(msg_rdata), 64'(e.msg));
            end
        end
    end

    initial begin
        logic [N-1:0] lk, ul;
        rst = 1'b1; lock_req = '0; unlock_req = '0; msg_wdata = '0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // Uncontended acquire and release with message.
        step(0, 8'h04, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 8'h04, 32'hCAFE0001);
        step(0, 0, 0, 0);
        // Handoff chain 0 -> 1 -> 3.
        step(0, 8'h01, 0, 0);
        step(0, 8'h0A, 0, 0);
        step(0, 0, 8'h01, 32'h11111111);
        step(0, 0, 8'h02, 32'h22222222);
        step(0, 0, 8'h08, 32'h33333333);
        step(0, 0, 0, 0);
        // Illegal unlocks while locked and while free.
        step(0, 8'h20, 0, 0);
        step(0, 0, 8'h08, 32'h12345678);
        step(0, 0, 0, 0);
        step(0, 0, 8'h20, 32'h00000001);
        step(0, 0, 8'h01, 32'h00000002);
        step(0, 0, 0, 0);
        // Owner unlocks and re-requests in the same cycle as another requester.
        step(0, 8'h04, 0, 0);
        step(0, 8'h44, 8'h04, 32'h3);
        step(0, 0, 8'h40, 32'h4);
        step(0, 0, 8'h04, 32'h5);
        step(0, 0, 0, 0);
        // Reset while owned with waiters.
        step(0, 8'h10, 0, 0);
        step(0, 8'h30, 0, 0);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        // Fairness: 0, 1, 7 re-request right at release.
        step(0, 8'h83, 0, 0);
        repeat (30) begin
            lk = '0;
            if (m_owner >= 0) lk[m_owner] = 1'b1;
            step(0, lk, lk, $urandom);
        end
        step(1, 0, 0, 0);
        // Randomised traffic with occasional illegal unlocks and resets.
        repeat (2000) begin
            lk = N'($urandom & $urandom & $urandom);
            ul = '0;
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) ul[m_owner] = 1'b1;
            if ($urandom_range(0, 15) == 0) ul[$urandom_range(0, N - 1)] = 1'b1;
            step(($urandom_range(0, 199) == 0), lk, ul, $urandom);
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d queued expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
